// File: rtl/xgriscv_ifetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues in-order memory requests and
// buffers returned instructions in a DEPTH-entry queue for the fetch stage.
module xgriscv_ifetch_queue #(
    parameter int unsigned          ADDR_SIZE  = 32,
    parameter int unsigned          INSTR_SIZE = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_SIZE-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_SIZE-1:0] imem_rsp_data,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    input  logic                  stall,
    output logic [INSTR_SIZE-1:0] instrF,
    output logic [ADDR_SIZE-1:0]  pcF,
    output logic                  validF
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_SIZE-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0]  pc_mem_q    [DEPTH];
    logic [ADDR_SIZE-1:0]  pc_mem_d    [DEPTH];
    logic [INSTR_SIZE-1:0] instr_mem_q [DEPTH];
    logic [INSTR_SIZE-1:0] instr_mem_d [DEPTH];
    logic [DEPTH-1:0]      filled_q, filled_d;
    logic [PTR_W-1:0]      alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]      fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]      head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]      alloc_cnt_q, alloc_cnt_d;
    logic [CNT_W-1:0]      pending_cnt_q, pending_cnt_d;
    logic [CNT_W-1:0]      discard_cnt_q, discard_cnt_d;

    logic accept;
    logic rsp_drop;
    logic rsp_fill;
    logic consume;

    // Requests stop at DEPTH outstanding (live entries plus responses still owed).
    assign imem_req_valid = !redirect && ((alloc_cnt_q + discard_cnt_q) < CNT_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign validF = filled_q[head_ptr_q];
    assign instrF = validF ? instr_mem_q[head_ptr_q] : '0;
    assign pcF    = validF ? pc_mem_q[head_ptr_q]    : '0;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (discard_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid && (discard_cnt_q == '0) && (pending_cnt_q != '0);
    assign consume  = validF && !stall;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
        filled_d      = filled_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        head_ptr_d    = head_ptr_q;
        alloc_cnt_d   = alloc_cnt_q;
        pending_cnt_d = pending_cnt_q;
        discard_cnt_d = discard_cnt_q;

        if (redirect) begin
            // Every unfilled request becomes a wrong-path response; this cycle's response is one of them.
            fetch_pc_d    = redirect_pc & ~ADDR_SIZE'(3);
            filled_d      = '0;
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            head_ptr_d    = '0;
            alloc_cnt_d   = '0;
            pending_cnt_d = '0;
            discard_cnt_d = discard_cnt_q + pending_cnt_q - CNT_W'(rsp_drop || rsp_fill);
        end else begin
            if (accept) begin
                pc_mem_d[alloc_ptr_q] = fetch_pc_q;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + ADDR_SIZE'(4);
            end
            if (rsp_fill) begin
                instr_mem_d[fill_ptr_q] = imem_rsp_data;
                filled_d[fill_ptr_q]    = 1'b1;
                fill_ptr_d              = fill_ptr_q + PTR_W'(1);
            end
            if (consume) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PTR_W'(1);
            end
            alloc_cnt_d   = alloc_cnt_q + CNT_W'(accept) - CNT_W'(consume);
            pending_cnt_d = pending_cnt_q + CNT_W'(accept) - CNT_W'(rsp_fill);
            discard_cnt_d = discard_cnt_q - CNT_W'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            filled_q      <= '0;
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            head_ptr_q    <= '0;
            alloc_cnt_q   <= '0;
            pending_cnt_q <= '0;
            discard_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            filled_q      <= filled_d;
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            head_ptr_q    <= head_ptr_d;
            alloc_cnt_q   <= alloc_cnt_d;
            pending_cnt_q <= pending_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= pc_mem_d[i];
                instr_mem_q[i] <= instr_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_ifetch_queue.sv
// Directed bench for xgriscv_ifetch_queue with an in-order, fixed-latency memory model.
module tb_xgriscv_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic        validF;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;
    int accepts  = 0;

    logic [31:0] q_addr[$];
    int          q_due[$];

    xgriscv_ifetch_queue #(
        .ADDR_SIZE (32),
        .INSTR_SIZE(32),
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .instrF        (instrF),
        .pcF           (pcF),
        .validF        (validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: record acceptance before the edge, then present this cycle's response.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (acc) begin
            q_addr.push_back(a);
            q_due.push_back(cyc + lat);
            accepts++;
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    // Asserts reset (memory is reset alongside), checks cleared outputs, releases in cycle 0.
    task automatic do_reset(input int l);
        reset          = 1'b0;
        q_addr.delete();
        q_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        lat            = l;
        #1;
        check("rst_validF", 32'(validF), 32'd0);
        check("rst_instrF", instrF, 32'd0);
        check("rst_pcF", pcF, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        cyc     = 0;
        accepts = 0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_req_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        #2;

        // Streaming: pcF 0,4,8,C on consecutive cycles from cycle 2
        do_reset(1);
        step();
        check("t1_c1_validF", 32'(validF), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t1_validF", 32'(validF), 32'd1);
            check("t1_pcF", pcF, 32'(4 * i));
            check("t1_instrF", instrF, mem_word(32'(4 * i)));
            step();
        end

        // Stall 10 cycles: exactly 4 requests, head frozen, then drain and resume
        do_reset(1);
        stall = 1'b1;
        repeat (10) step();
        check("t2_accepts", 32'(accepts), 32'd4);
        check("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        check("t2_frozen_validF", 32'(validF), 32'd1);
        check("t2_frozen_pcF", pcF, 32'h0);
        check("t2_frozen_instrF", instrF, mem_word(32'h0));
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_validF", 32'(validF), 32'd1);
            check("t2_drain_pcF", pcF, 32'(4 * i));
            step();
        end
        check("t2_resume_validF", 32'(validF), 32'd1);
        check("t2_resume_pcF", pcF, 32'h10);

        // Latency 3, two requests in flight, redirect to 0x100
        do_reset(3);
        step();
        step();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_req_valid_redir", 32'(imem_req_valid), 32'd0);
        step();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            check("t3_no_wrong_path", 32'(validF), 32'd0);
            step();
        end
        check("t3_validF", 32'(validF), 32'd1);
        check("t3_pcF", pcF, 32'h100);
        check("t3_instrF", instrF, mem_word(32'h100));

        // Redirect coinciding with a response and a would-be consume, unaligned target
        do_reset(1);
        step();
        step();
        check("t4_pre_pcF", pcF, 32'h0);
        check("t4_pre_rsp", 32'(imem_rsp_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check("t4_req_valid_redir", 32'(imem_req_valid), 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check("t4_post_validF", 32'(validF), 32'd0);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_req_addr", imem_req_addr, 32'h100);
        step();
        step();
        check("t4_validF", 32'(validF), 32'd1);
        check("t4_pcF", pcF, 32'h100);
        step();
        check("t4_pcF_next", pcF, 32'h104);

        // Ready toggling 1,0,0,1: address held, no duplicated or skipped PCs
        do_reset(1);
        step();
        imem_req_ready = 1'b0;
        #1;
        check("t5_c1_addr", imem_req_addr, 32'h4);
        check("t5_c1_req_valid", 32'(imem_req_valid), 32'd1);
        step();
        check("t5_c2_addr", imem_req_addr, 32'h4);
        check("t5_c2_pcF", pcF, 32'h0);
        step();
        imem_req_ready = 1'b1;
        check("t5_c3_addr", imem_req_addr, 32'h4);
        check("t5_c3_validF", 32'(validF), 32'd0);
        step();
        check("t5_c4_validF", 32'(validF), 32'd0);
        step();
        check("t5_c5_validF", 32'(validF), 32'd1);
        check("t5_c5_pcF", pcF, 32'h4);
        step();
        check("t5_c6_pcF", pcF, 32'h8);

        // Reset with the queue full, then restart at RESET_PC
        do_reset(1);
        stall = 1'b1;
        repeat (6) step();
        check("t6_full_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_full_validF", 32'(validF), 32'd1);
        do_reset(1);
        step();
        step();
        check("t6_restart_validF", 32'(validF), 32'd1);
        check("t6_restart_pcF", pcF, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
